// File: rtl/led_matrix_pkg.sv
// Shared geometry and scan state encoding for the 5x7 LED matrix scanner.
package led_matrix_pkg;

  localparam int NUM_COLS = 5;
  localparam int NUM_ROWS = 7;
  localparam int FRAME_W  = NUM_COLS * NUM_ROWS;
  localparam int COL_W    = 3;
  localparam int TIMER_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/led_matrix_scan_ctrl_scan_timer.sv
// Down-counter timing the blank and dwell intervals; done is high once the
// loaded count has run out, so a load of N-1 yields a phase of N cycles.
module scan_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count;

  // Count down to zero and hold there; a load restarts the interval.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Column scanner for a 5x7 LED matrix with a double-buffered frame store
// that only swaps at the frame boundary, so the display never tears.
module led_matrix_scan_ctrl
  import led_matrix_pkg::*;
#(
  parameter int DWELL_CYCLES   = 10000,
  parameter int BLANK_CYCLES   = 16,
  parameter int COL_ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic [FRAME_W-1:0] rows_values,
  output logic [COL_W-1:0]   bin_number,
  output logic [NUM_COLS-1:0] col_enable,
  output logic               frame_start
);

  localparam logic [TIMER_W-1:0]  DWELL_LOAD = TIMER_W'(DWELL_CYCLES - 1);
  localparam logic [TIMER_W-1:0]  BLANK_LOAD = TIMER_W'(BLANK_CYCLES - 1);
  localparam logic [NUM_COLS-1:0] COL_OFF    = (COL_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [COL_W-1:0]    LAST_COL   = COL_W'(NUM_COLS - 1);

  scan_state_t state, state_next;
  logic [COL_W-1:0]    bin_next;
  logic [NUM_COLS-1:0] col_next;
  logic [NUM_COLS-1:0] col_onehot;
  logic [NUM_COLS-1:0] col_lit;
  logic                start_next;
  logic                timer_load;
  logic [TIMER_W-1:0]  timer_value;
  logic                timer_done;
  logic                boundary;

  logic [FRAME_W-1:0]  pending;
  logic                pending_full;
  logic                pending_full_next;
  logic                accept;
  logic                load_rows;

  assign col_onehot = NUM_COLS'(1) << bin_number;
  assign col_lit    = (COL_ACTIVE_LOW != 0) ? ~col_onehot : col_onehot;

  scan_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (~enable),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  // Next-state and next-output decode; disabling drops straight to IDLE.
  always_comb begin
    state_next  = state;
    bin_next    = bin_number;
    col_next    = col_enable;
    start_next  = 1'b0;
    timer_load  = 1'b0;
    timer_value = '0;
    boundary    = 1'b0;
    if (!enable) begin
      state_next = ST_IDLE;
      bin_next   = '0;
      col_next   = COL_OFF;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next  = ST_BLANK;
          bin_next    = '0;
          col_next    = COL_OFF;
          start_next  = 1'b1;
          timer_load  = 1'b1;
          timer_value = BLANK_LOAD;
        end
        ST_BLANK: begin
          if (timer_done) begin
            state_next  = ST_SHOW;
            col_next    = col_lit;
            timer_load  = 1'b1;
            timer_value = DWELL_LOAD;
          end
        end
        ST_SHOW: begin
          if (timer_done) begin
            state_next  = ST_BLANK;
            col_next    = COL_OFF;
            timer_load  = 1'b1;
            timer_value = BLANK_LOAD;
            if (bin_number == LAST_COL) begin
              bin_next   = '0;
              boundary   = 1'b1;
              start_next = 1'b1;
            end else begin
              bin_next = bin_number + COL_W'(1);
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
          bin_next   = '0;
          col_next   = COL_OFF;
        end
      endcase
    end
  end

  // Scan state and column outputs are all registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      bin_number  <= '0;
      col_enable  <= COL_OFF;
      frame_start <= 1'b0;
    end else begin
      state       <= state_next;
      bin_number  <= bin_next;
      col_enable  <= col_next;
      frame_start <= start_next;
    end
  end

  // At a boundary the pending frame moves to the display, which empties the
  // slot before any same-cycle accept; ready mirrors the next fill state.
  assign accept            = frame_valid && frame_ready;
  assign load_rows         = boundary && pending_full;
  assign pending_full_next = accept || (pending_full && !load_rows);

  // Pending/display buffers keep running regardless of enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= '0;
      pending_full <= 1'b0;
      rows_values  <= '0;
      frame_ready  <= 1'b1;
    end else begin
      if (load_rows) begin
        rows_values <= pending;
      end
      if (accept) begin
        pending <= frame_data;
      end
      pending_full <= pending_full_next;
      frame_ready  <= !pending_full_next;
    end
  end

endmodule
